// File: rtl/dpram_access_scheduler.sv
// Two-channel request scheduler in front of a 2-port synchronous RAM; same-address read/write collisions are serialised.
// Latency: grant and RAM drive are combinational; read response is valid exactly 1 cycle after the read is granted.
// Backpressure: on a collision only the priority channel is ready; the other must hold its request until it is accepted.
//
// Ports:
//   clk, rst_n                     clock and asynchronous active-low reset
//   req_valid_i/req_ready_o/req_we_i, req_addr{0,1}_i, req_wdata{0,1}_i
//                                  per-channel request handshake, bit i = channel i
//   rsp_valid_o, rsp_rdata{0,1}_o  per-channel read response, data held while no response
//   mem_we_o, mem_addr{0,1}_o, mem_wdata{0,1}_o, mem_rdata{0,1}_i
//                                  RAM port drive and registered RAM read data
//   conflict_cnt_o                 saturating count of collision (stall) cycles
module dpram_access_scheduler #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0]            req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr0_i,
  input  logic [ADDR_WIDTH-1:0] req_addr1_i,
  input  logic [DATA_WIDTH-1:0] req_wdata0_i,
  input  logic [DATA_WIDTH-1:0] req_wdata1_i,
  output logic [1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata0_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata1_o,
  output logic [1:0]            mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr0_o,
  output logic [ADDR_WIDTH-1:0] mem_addr1_o,
  output logic [DATA_WIDTH-1:0] mem_wdata0_o,
  output logic [DATA_WIDTH-1:0] mem_wdata1_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata0_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata1_i,
  output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

  logic                  conflict;
  logic [1:0]            ready;
  logic [1:0]            grant;

  // prio_q names the channel that wins the next collision
  logic                  prio_q, prio_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] hold0_q, hold0_d;
  logic [DATA_WIDTH-1:0] hold1_q, hold1_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // Two reads of one address are harmless; anything involving a write is a collision.
  always_comb begin
    conflict = (&req_valid_i) && (req_addr0_i == req_addr1_i) && (|req_we_i);
    ready[0] = ~conflict | ~prio_q;
    ready[1] = ~conflict |  prio_q;
    grant    = req_valid_i & ready;
  end

  assign req_ready_o  = ready;
  assign mem_addr0_o  = req_addr0_i;
  assign mem_addr1_o  = req_addr1_i;
  assign mem_wdata0_o = req_wdata0_i;
  assign mem_wdata1_o = req_wdata1_i;
  assign mem_we_o     = grant & req_we_i;

  always_comb begin
    prio_d      = prio_q ^ conflict;
    rsp_valid_d = grant & ~req_we_i;
    cnt_d       = cnt_q;
    if (conflict && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    // The RAM's output register already provides the 1-cycle alignment, so its data is
    // forwarded directly while a response is valid and captured only to hold it afterwards.
    hold0_d = rsp_valid_q[0] ? mem_rdata0_i : hold0_q;
    hold1_d = rsp_valid_q[1] ? mem_rdata1_i : hold1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      hold0_q     <= '0;
      hold1_q     <= '0;
      cnt_q       <= '0;
    end else begin
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata0_o   = rsp_valid_q[0] ? mem_rdata0_i : hold0_q;
  assign rsp_rdata1_o   = rsp_valid_q[1] ? mem_rdata1_i : hold1_q;
  assign conflict_cnt_o = cnt_q;

endmodule
